// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - digit-serial MSB-first magnitude comparator with start/done handshake
module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("seq_magnitude_comparator: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] a_load;
    logic [WIDTH-1:0] b_load;
    logic [DIGIT-1:0] digit_a;
    logic [DIGIT-1:0] digit_b;

    // Signed compare reduces to unsigned by flipping the sign bit of both operands at latch time
    always_comb begin
        a_load = a;
        b_load = b;
        if (signed_mode) begin
            a_load[WIDTH-1] = ~a[WIDTH-1];
            b_load[WIDTH-1] = ~b[WIDTH-1];
        end
    end

    // Operands are shifted left each step, so the digit under test is always the top one
    assign digit_a = a_r[WIDTH-1 -: DIGIT];
    assign digit_b = b_r[WIDTH-1 -: DIGIT];

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_r   <= a_load;
                        b_r   <= b_load;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (digit_a != digit_b) begin
                        eq    <= 1'b0;
                        gt    <= (digit_a > digit_b);
                        lt    <= (digit_a < digit_b);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (idx == '0) begin
                        eq    <= 1'b1;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                        a_r <= a_r << DIGIT;
                        b_r <= b_r << DIGIT;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a_load;
                        b_r   <= b_load;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= S_COMPARE;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - randomized and directed bench for seq_magnitude_comparator
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start1 = 1'b0, sm1 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0;
    logic       busy1, done1, eq1, gt1, lt1;

    logic       start4 = 1'b0, sm4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, eq4, gt4, lt4;

    logic       use4 = 1'b0;
    logic       cur_busy, cur_done;
    logic [2:0] cur_res;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(sm1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
    );

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .eq(eq4), .gt(gt4), .lt(lt4)
    );

    always #5 clk = ~clk;

    assign cur_busy = use4 ? busy4 : busy1;
    assign cur_done = use4 ? done4 : done1;
    assign cur_res  = use4 ? {eq4, gt4, lt4} : {eq1, gt1, lt1};

    // Reference: result from plain (signed) arithmetic, latency from the first differing digit
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sm,
                                  input int dig, output logic [2:0] res, output int lat);
        int nd, mask, ai, bi, sh;
        nd   = 8 / dig;
        mask = (1 << dig) - 1;
        ai   = int'(a);
        bi   = int'(b);
        lat  = nd + 1;
        for (int j = 1; j <= nd; j++) begin
            sh = (nd - j) * dig;
            if (((ai >> sh) & mask) != ((bi >> sh) & mask)) begin
                lat = j + 1;
                break;
            end
        end
        if (sm) res = ($signed(a) == $signed(b)) ? R_EQ : (($signed(a) > $signed(b)) ? R_GT : R_LT);
        else    res = (a == b) ? R_EQ : ((a > b) ? R_GT : R_LT);
    endfunction

    task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b, input logic sm);
        if (use4) begin start4 = s; a4 = a; b4 = b; sm4 = sm; end
        else      begin start1 = s; a1 = a; b1 = b; sm1 = sm; end
    endtask

    // Issues one operation from a #1-after-edge position; cyc counts samples from the start edge
    task automatic do_op(input logic sel, input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input int mid, output int cyc, output int busy_cnt,
                         output logic [2:0] hold, output logic [2:0] res);
        use4 = sel;
        drive(1'b1, a, b, sm);
        @(posedge clk); #1;
        drive(1'b0, a, b, sm);
        cyc = 1;
        busy_cnt = 0;
        hold = cur_res;
        while (!cur_done && cyc < 40) begin
            if (cur_busy) busy_cnt++;
            if (mid != 0 && cyc == mid) drive(1'b1, ~a, ~b, ~sm);
            else drive(1'b0, ~a, ~b, ~sm);
            @(posedge clk); #1;
            cyc++;
        end
        drive(1'b0, a, b, sm);
        res = cur_res;
    endtask

    task automatic test_reset;
        tests++;
        if ({busy1, done1, eq1, gt1, lt1} !== 5'b0) begin
            fails++;
            $display("FAIL reset_dut1: got %b, want 00000", {busy1, done1, eq1, gt1, lt1});
        end
        tests++;
        if ({busy4, done4, eq4, gt4, lt4} !== 5'b0) begin
            fails++;
            $display("FAIL reset_dut4: got %b, want 00000", {busy4, done4, eq4, gt4, lt4});
        end
    endtask

    task automatic test_reset_mid;
        logic saw_done;
        use4 = 1'b0;
        drive(1'b1, 8'h00, 8'hFF, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'hFF, 1'b0);
        saw_done = done1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if (busy1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_busy: got %b, want 0", busy1);
        end
        for (int i = 0; i < 5; i++) begin
            saw_done = saw_done | done1;
            @(posedge clk); #1;
        end
        tests++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_done: done pulsed, want no pulse");
        end
        tests++;
        if ({eq1, gt1, lt1} !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid_res: got %b, want 000", {eq1, gt1, lt1});
        end
    endtask

    task automatic check_op(input string name, input logic sel, input logic [7:0] a, input logic [7:0] b,
                            input logic sm, input int mid, input int exp_cyc, input logic [2:0] exp_res,
                            input int exp_busy);
        int cyc, bc;
        logic [2:0] hold, res, prev;
        prev = sel ? {eq4, gt4, lt4} : {eq1, gt1, lt1};
        do_op(sel, a, b, sm, mid, cyc, bc, hold, res);
        tests++;
        if (cyc !== exp_cyc) begin
            fails++;
            $display("FAIL %s_latency: got %0d, want %0d", name, cyc, exp_cyc);
        end
        tests++;
        if (res !== exp_res) begin
            fails++;
            $display("FAIL %s_result: got %b, want %b", name, res, exp_res);
        end
        tests++;
        if (hold !== prev) begin
            fails++;
            $display("FAIL %s_hold_at_start: got %b, want %b", name, hold, prev);
        end
        if (exp_busy >= 0) begin
            tests++;
            if (bc !== exp_busy) begin
                fails++;
                $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bc, exp_busy);
            end
        end
    endtask

    task automatic test_unsigned_msb;
        check_op("unsigned_msb", 1'b0, 8'h80, 8'h7F, 1'b0, 0, 2, R_GT, 1);
    endtask

    task automatic test_signed_msb;
        check_op("signed_msb", 1'b0, 8'h80, 8'h7F, 1'b1, 0, 2, R_LT, 1);
    endtask

    task automatic test_equal;
        check_op("equal", 1'b0, 8'hA5, 8'hA5, 1'b0, 0, 9, R_EQ, 8);
    endtask

    task automatic test_lsb_diff;
        check_op("lsb_diff_start_ignored", 1'b0, 8'h01, 8'h00, 1'b0, 3, 9, R_GT, 8);
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [2:0] r1;
        logic gap_busy;
        use4 = 1'b1;
        drive(1'b1, 8'h3C, 8'h3D, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 8'hF0, 8'h10, 1'b1);
        cyc = 1;
        while (!done4 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        r1 = {eq4, gt4, lt4};
        tests++;
        if (cyc !== 3) begin
            fails++;
            $display("FAIL b2b_first_latency: got %0d, want 3", cyc);
        end
        tests++;
        if (r1 !== R_LT) begin
            fails++;
            $display("FAIL b2b_first_result: got %b, want %b", r1, R_LT);
        end
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        gap_busy = busy4;
        tests++;
        if (gap_busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_no_idle: busy got %b, want 1", gap_busy);
        end
        @(posedge clk); #1;
        tests++;
        if ({done4, eq4, gt4, lt4} !== {1'b1, R_LT}) begin
            fails++;
            $display("FAIL b2b_second: got done/res %b, want 1001", {done4, eq4, gt4, lt4});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [7:0] a, b;
        logic sm, sel;
        logic [2:0] exp_res;
        int exp_lat;
        for (int n = 0; n < 80; n++) begin
            sel = 1'($urandom_range(0, 1));
            sm  = 1'($urandom_range(0, 1));
            a   = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (8'h01 << $urandom_range(0, 7));
                default: b = 8'($urandom);
            endcase
            model(a, b, sm, sel ? 4 : 1, exp_res, exp_lat);
            check_op(sel ? "rand_d4" : "rand_d1", sel, a, b, sm, 0, exp_lat, exp_res, exp_lat - 1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset_mid;
        test_unsigned_msb;
        test_signed_msb;
        test_equal;
        test_lsb_diff;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
